instr_fetch_unit: RTL and testbench

Instruction fetch stage and IF/ID pipeline register for the five-stage RISC-V-subset CPU. It drives the instruction stream into the control unit's `i_opcode`/`i_nop` inputs. It keeps the PC, issues one-outstanding-request reads to instruction memory, buffers a response that arrives during a stall, and handles branch redirects and flushes. It stops fetching after it loads the DONE opcode.

---
 rtl/instr_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage plus IF/ID register: one outstanding imem read,
// stall-time response buffering, branch redirect/flush, halt on DONE_OP.
module instr_fetch_unit #(
    parameter int unsigned     PC_W     = 64,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [6:0]      DONE_OP  = 7'b1111111
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_branch_taken,
    input  logic [PC_W-1:0] i_branch_target,
    output logic            o_imem_req,
    output logic [PC_W-1:0] o_imem_addr,
    input  logic            i_imem_valid,
    input  logic [31:0]     i_imem_rdata,
    output logic [31:0]     o_instr,
    output logic [6:0]      o_opcode,
    output logic [PC_W-1:0] o_pc,
    output logic            o_nop,
    output logic            o_halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP,
        S_HALT
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pend_pc_q;
    logic [31:0]     pend_instr_q;
    logic            pend_vld_q;
    logic [31:0]     instr_q;
    logic [6:0]      opcode_q;
    logic [PC_W-1:0] ifid_pc_q;
    logic            nop_q;
    logic            req_q;
    logic            halted_q;

    logic            ld;
    logic [31:0]     ld_instr;
    logic [PC_W-1:0] ld_pc;
    logic            ld_done;

    // IF/ID load source: a fresh response in WAIT or the buffered one in HOLD
    always_comb begin
        ld       = 1'b0;
        ld_instr = i_imem_rdata;
        ld_pc    = pc_q;
        if (!i_branch_taken && !i_stall) begin
            if (state_q == S_WAIT && i_imem_valid) begin
                ld = 1'b1;
            end else if (state_q == S_HOLD && pend_vld_q) begin
                ld       = 1'b1;
                ld_instr = pend_instr_q;
                ld_pc    = pend_pc_q;
            end
        end
        ld_done = (ld_instr[6:0] == DONE_OP);
    end

    always_comb begin
        state_d = state_q;
        if (i_branch_taken) begin
            case (state_q)
                S_REQ:          state_d = S_DROP;
                S_WAIT, S_DROP: state_d = i_imem_valid ? S_REQ : S_DROP;
                default:        state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ:  state_d = S_WAIT;
                S_WAIT: begin
                    if (i_imem_valid) begin
                        if (i_stall) state_d = S_HOLD;
                        else         state_d = ld_done ? S_HALT : S_REQ;
                    end
                end
                S_HOLD: if (ld) state_d = ld_done ? S_HALT : S_REQ;
                S_DROP: if (i_imem_valid) state_d = S_REQ;
                S_HALT: state_d = S_HALT;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            pend_pc_q    <= '0;
            pend_instr_q <= '0;
            pend_vld_q   <= 1'b0;
            instr_q      <= '0;
            opcode_q     <= '0;
            ifid_pc_q    <= '0;
            nop_q        <= 1'b1;
            req_q        <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= (state_d == S_REQ);
            halted_q <= (state_d == S_HALT);
            if (i_branch_taken) begin
                // Flush wins over stall; o_pc keeps the last loaded address
                pc_q       <= i_branch_target;
                pend_vld_q <= 1'b0;
                instr_q    <= '0;
                opcode_q   <= '0;
                nop_q      <= 1'b1;
            end else begin
                if (state_q == S_WAIT && i_imem_valid) begin
                    pc_q <= pc_q + PC_W'(4);
                    if (i_stall) begin
                        pend_instr_q <= i_imem_rdata;
                        pend_pc_q    <= pc_q;
                        pend_vld_q   <= 1'b1;
                    end
                end
                if (ld) begin
                    instr_q   <= ld_instr;
                    opcode_q  <= ld_instr[6:0];
                    ifid_pc_q <= ld_pc;
                    nop_q     <= 1'b0;
                    if (state_q == S_HOLD) pend_vld_q <= 1'b0;
                end else if (!i_stall) begin
                    instr_q  <= '0;
                    opcode_q <= '0;
                    nop_q    <= 1'b1;
                end
            end
        end
    end

    assign o_imem_req  = req_q;
    assign o_imem_addr = pc_q;
    assign o_instr     = instr_q;
    assign o_opcode    = opcode_q;
    assign o_pc        = ifid_pc_q;
    assign o_nop       = nop_q;
    assign o_halted    = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: cycle vector table for the directed corner cases,
// hand-written halt/reset sequences, and a scoreboarded random-stall run.
module tb_instr_fetch_unit;

    localparam int unsigned PC_W = 64;

    logic            clk = 1'b0;
    logic            rst, stall, br, valid;
    logic [PC_W-1:0] tgt;
    logic [31:0]     rdata;
    logic            o_imem_req, o_nop, o_halted;
    logic [PC_W-1:0] o_imem_addr, o_pc;
    logic [31:0]     o_instr;
    logic [6:0]      o_opcode;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .PC_W    (PC_W),
        .RESET_PC(64'h0),
        .DONE_OP (7'b1111111)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_branch_taken (br),
        .i_branch_target(tgt),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_valid   (valid),
        .i_imem_rdata   (rdata),
        .o_instr        (o_instr),
        .o_opcode       (o_opcode),
        .o_pc           (o_pc),
        .o_nop          (o_nop),
        .o_halted       (o_halted)
    );

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     ins;
    } exp_t;

    typedef struct {
        logic            rst, stall, br;
        logic [PC_W-1:0] tgt;
        int              lat;
        logic            req;
        logic [PC_W-1:0] addr;
        logic            nop;
        logic [PC_W-1:0] pc;
        logic [31:0]     ins;
    } vec_t;

    int unsigned     n_chk = 0, n_pass = 0;
    logic [PC_W-1:0] maddr, done_addr;
    int              mcnt;
    bit              sb_en = 1'b0;
    exp_t            sb[$];
    vec_t            tbl[$];

    function automatic logic [31:0] word(input logic [PC_W-1:0] a);
        if (a == done_addr) return 32'h0000007F;
        return {a[28:4], (a[2] ? 7'h33 : 7'h13)};
    endfunction

    function automatic void add(input logic r, input logic s, input logic b,
                                input logic [PC_W-1:0] t, input int lat,
                                input logic req, input logic [PC_W-1:0] addr,
                                input logic nop, input logic [PC_W-1:0] pc,
                                input logic [31:0] ins);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.lat = lat;
        v.req = req; v.addr = addr; v.nop = nop; v.pc = pc; v.ins = ins;
        tbl.push_back(v);
    endfunction

    // Memory model: latches a request, answers `lat` cycles later
    task automatic cycle_end(input int lat);
        exp_t e;
        if (o_imem_req === 1'b1) begin
            maddr = o_imem_addr;
            mcnt  = lat;
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
        rdata = '0;
        if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                valid = 1'b1;
                rdata = word(maddr);
                if (sb_en) begin
                    e.pc  = maddr;
                    e.ins = word(maddr);
                    sb.push_back(e);
                end
            end
        end
    endtask

    task automatic check(input string name, input logic req, input logic [PC_W-1:0] addr,
                         input logic nop, input logic [PC_W-1:0] pc,
                         input logic [31:0] ins, input logic halt);
        n_chk++;
        if (o_imem_req === req && o_imem_addr === addr && o_nop === nop && o_pc === pc &&
            o_instr === ins && o_opcode === ins[6:0] && o_halted === halt)
            n_pass++;
        else
            $display("FAIL %s: got req=%0b addr=%0h nop=%0b pc=%0h instr=%08h opc=%02h halt=%0b ; want req=%0b addr=%0h nop=%0b pc=%0h instr=%08h opc=%02h halt=%0b",
                     name, o_imem_req, o_imem_addr, o_nop, o_pc, o_instr, o_opcode, o_halted,
                     req, addr, nop, pc, ins, ins[6:0], halt);
    endtask

    initial begin
        exp_t e;
        logic prev_nop;
        logic [PC_W-1:0] prev_pc;
        int unsigned loads;

        rst = 1'b1; stall = 1'b0; br = 1'b0; tgt = '0;
        valid = 1'b0; rdata = '0; mcnt = 0; maddr = '0;
        done_addr = '1;

        //   rst stl br  tgt       lat  req addr      nop pc        instr
        add(0, 0, 0, 64'h0,  1,   0, 64'h0,   1, 64'h0,  32'h0);     // reset state
        add(0, 0, 0, 64'h0,  1,   1, 64'h0,   1, 64'h0,  32'h0);
        add(0, 0, 0, 64'h0,  1,   0, 64'h0,   1, 64'h0,  32'h0);
        add(0, 0, 0, 64'h0,  1,   1, 64'h4,   0, 64'h0,  word(64'h0));
        add(0, 0, 0, 64'h0,  1,   0, 64'h4,   1, 64'h0,  32'h0);
        add(0, 0, 0, 64'h0,  1,   1, 64'h8,   0, 64'h4,  word(64'h4));
        add(0, 0, 0, 64'h0,  1,   0, 64'h8,   1, 64'h4,  32'h0);
        add(1, 0, 0, 64'h0,  1,   1, 64'hC,   0, 64'h8,  word(64'h8));
        add(0, 0, 0, 64'h0,  1,   0, 64'h0,   1, 64'h0,  32'h0);     // late valid in IDLE
        add(0, 0, 0, 64'h0,  1,   1, 64'h0,   1, 64'h0,  32'h0);
        add(0, 0, 0, 64'h0,  1,   0, 64'h0,   1, 64'h0,  32'h0);
        add(0, 1, 0, 64'h0,  1,   1, 64'h4,   0, 64'h0,  word(64'h0));
        add(0, 1, 0, 64'h0,  1,   0, 64'h4,   0, 64'h0,  word(64'h0)); // response while stalled
        add(0, 1, 0, 64'h0,  1,   0, 64'h8,   0, 64'h0,  word(64'h0));
        add(0, 1, 0, 64'h0,  1,   0, 64'h8,   0, 64'h0,  word(64'h0));
        add(0, 0, 0, 64'h0,  1,   0, 64'h8,   0, 64'h0,  word(64'h0));
        add(0, 0, 0, 64'h0,  2,   1, 64'h8,   0, 64'h4,  word(64'h4));
        add(0, 0, 1, 64'h40, 1,   0, 64'h8,   1, 64'h4,  32'h0);     // branch in WAIT
        add(0, 0, 0, 64'h0,  1,   0, 64'h40,  1, 64'h4,  32'h0);     // stale word dropped
        add(0, 0, 0, 64'h0,  1,   1, 64'h40,  1, 64'h4,  32'h0);
        add(0, 0, 0, 64'h0,  1,   0, 64'h40,  1, 64'h4,  32'h0);
        add(0, 1, 1, 64'h80, 1,   1, 64'h44,  0, 64'h40, word(64'h40)); // branch + stall
        add(0, 0, 0, 64'h0,  1,   0, 64'h80,  1, 64'h40, 32'h0);
        add(0, 0, 0, 64'h0,  1,   1, 64'h80,  1, 64'h40, 32'h0);
        add(0, 0, 0, 64'h0,  1,   0, 64'h80,  1, 64'h40, 32'h0);
        add(0, 0, 0, 64'h0,  1,   1, 64'h84,  0, 64'h80, word(64'h80));

        cycle_end(1);
        cycle_end(1);
        foreach (tbl[i]) begin
            check($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].nop,
                  tbl[i].pc, tbl[i].ins, 1'b0);
            rst   = tbl[i].rst;
            stall = tbl[i].stall;
            br    = tbl[i].br;
            tgt   = tbl[i].tgt;
            cycle_end(tbl[i].lat);
        end
        stall = 1'b0; br = 1'b0;

        // Halt on DONE at address 8, then resume by branching
        done_addr = 64'h8;
        rst = 1'b1;
        cycle_end(1);
        rst = 1'b0;
        for (int k = 0; k < 7; k++) cycle_end(1);
        check("halt_show", 1'b0, 64'hC, 1'b0, 64'h8, 32'h0000007F, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cycle_end(1);
            check($sformatf("halt_idle%0d", k), 1'b0, 64'hC, 1'b1, 64'h8, 32'h0, 1'b1);
        end
        br = 1'b1; tgt = 64'h20;
        cycle_end(1);
        br = 1'b0;
        check("resume", 1'b1, 64'h20, 1'b1, 64'h8, 32'h0, 1'b0);

        // Reset while a slow response is outstanding
        cycle_end(3);
        rst = 1'b1;
        cycle_end(1);
        rst = 1'b0;
        check("rst_mid", 1'b0, 64'h0, 1'b1, 64'h0, 32'h0, 1'b0);
        cycle_end(1);
        check("rst_req1", 1'b1, 64'h0, 1'b1, 64'h0, 32'h0, 1'b0);
        cycle_end(1);
        check("rst_stale", 1'b0, 64'h0, 1'b1, 64'h0, 32'h0, 1'b0);
        cycle_end(1);
        check("rst_first", 1'b1, 64'h4, 1'b0, 64'h0, word(64'h0), 1'b0);

        // Random stalls and latencies, every response must reach IF/ID in order
        done_addr = '1;
        rst = 1'b1;
        cycle_end(1);
        rst = 1'b0;
        mcnt = 0; valid = 1'b0; rdata = '0;
        sb.delete();
        sb_en = 1'b1;
        prev_nop = 1'b1; prev_pc = '0; loads = 0;
        for (int c = 0; c < 120; c++) begin
            if (o_nop === 1'b0 && (prev_nop || o_pc !== prev_pc)) begin
                loads++;
                n_chk++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_load: got unexpected load pc=%0h instr=%08h, want none", o_pc, o_instr);
                end else begin
                    e = sb.pop_front();
                    if (o_pc === e.pc && o_instr === e.ins && o_opcode === e.ins[6:0]) n_pass++;
                    else $display("FAIL sb_load: got pc=%0h instr=%08h opc=%02h, want pc=%0h instr=%08h",
                                  o_pc, o_instr, o_opcode, e.pc, e.ins);
                end
            end
            prev_nop = o_nop;
            prev_pc  = o_pc;
            stall = (c < 110) ? ($urandom_range(0, 2) == 0) : 1'b0;
            cycle_end(int'($urandom_range(1, 3)));
        end
        stall = 1'b0;
        n_chk++;
        if (loads >= 15 && sb.size() <= 1) n_pass++;
        else $display("FAIL sb_drain: got loads=%0d pending=%0d, want loads>=15 pending<=1", loads, sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
